// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - stage_e     : symbolic stage indices of the default 6-stage core
//   - PC_SW       : stage index width for the default core
//   - RST_ENABLE  : active level of the synchronous reset
//   - STOP        : value of a stall bit that freezes a stage register
//   - PC_REQ_STAGE_DEF : default binding of the three stall requesters
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int PC_NUM_STAGES = 6;
    localparam int PC_NUM_REQ    = 3;
    localparam int PC_SW         = $clog2(PC_NUM_STAGES);

    typedef enum logic [PC_SW-1:0] {
        STG_PC  = 3'd0,
        STG_IF  = 3'd1,
        STG_ID  = 3'd2,
        STG_EX  = 3'd3,
        STG_MEM = 3'd4,
        STG_WB  = 3'd5
    } stage_e;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;

    // req0 (decode hazard) freezes through ID; req1 (MEM) and req2 (RAM)
    // freeze everything up to and including EX.
    localparam logic [PC_NUM_REQ*PC_SW-1:0] PC_REQ_STAGE_DEF = {STG_EX, STG_EX, STG_ID};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the controller's request inputs and stall/flush/status outputs.
//   master : the pipeline side (drives rdy, stall_req, flush_req, flush_stage)
//   slave  : the controller (drives stall, flush, flush_pending,
//            stall_timeout, perf_stall_cycles, perf_flush_count)
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter  int NUM_STAGES = 6,
    parameter  int NUM_REQ    = 3,
    localparam int SW         = $clog2(NUM_STAGES)
);
    logic                  rdy;
    logic [NUM_REQ-1:0]    stall_req;
    logic                  flush_req;
    logic [SW-1:0]         flush_stage;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
    logic                  flush_pending;
    logic                  stall_timeout;
    logic [31:0]           perf_stall_cycles;
    logic [31:0]           perf_flush_count;

    modport master (
        output rdy, stall_req, flush_req, flush_stage,
        input  stall, flush, flush_pending, stall_timeout,
               perf_stall_cycles, perf_flush_count
    );

    modport slave (
        input  rdy, stall_req, flush_req, flush_stage,
        output stall, flush, flush_pending, stall_timeout,
               perf_stall_cycles, perf_flush_count
    );
endinterface

// File: rtl/pipeline_ctrl_thermo_mask.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_thermo_mask
// Turns a stage index into a thermometer mask: mask[k] = valid && (k <= idx).
//   idx   : deepest stage covered (inclusive)
//   valid : 0 yields an all-zero mask
//   mask  : N-bit thermometer
// -----------------------------------------------------------------------------
module pipeline_ctrl_thermo_mask #(
    parameter int N  = 6,
    parameter int IW = $clog2(N)
) (
    input  logic [IW-1:0] idx,
    input  logic          valid,
    output logic [N-1:0]  mask
);
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign mask[gi] = valid && (IW'(gi) <= idx);
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Pipeline hazard controller: merges stall requests into a thermometer stall
// vector, applies or defers flush requests, and runs a stall watchdog.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   ctl : pipeline_ctrl_if.slave (rdy, stall_req, flush_req, flush_stage in;
//         stall, flush, flush_pending, stall_timeout, perf counters out)
// Optional build macro: PIPE_CTRL_PERF_EN enables the two 32-bit perf
// counters; without it both perf outputs read zero.
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter  int                        NUM_STAGES = 6,
    parameter  int                        NUM_REQ    = 3,
    localparam int                        SW         = $clog2(NUM_STAGES),
    parameter  logic [NUM_REQ*SW-1:0]     REQ_STAGE  = PC_REQ_STAGE_DEF,
    parameter  int                        TIMEOUT    = 1024
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  ctl
);
    logic [SW-1:0]         req_lvl [NUM_REQ];
    logic [SW-1:0]         stall_lvl;
    logic                  stall_any;
    logic [NUM_STAGES-1:0] stall_mask;
    logic [NUM_STAGES-1:0] flush_mask;
    logic [NUM_STAGES-1:0] stall_o;
    logic [SW-1:0]         req_f;
    logic [SW-1:0]         pend_f;
    logic [SW-1:0]         eff_f;
    logic                  flush_any;
    logic                  apply;
    logic                  flush_pending_reg;
    logic [SW-1:0]         pend_stage_reg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_lvl[gi] = REQ_STAGE[gi*SW +: SW];
    end

    // Deepest requested level wins, independent of requester order.
    always_comb begin
        stall_any = 1'b0;
        stall_lvl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ctl.stall_req[i]) begin
                stall_any = 1'b1;
                if (req_lvl[i] > stall_lvl) stall_lvl = req_lvl[i];
            end
        end
    end

    // A new request and a deferred one merge into the deeper of the two.
    always_comb begin
        req_f     = ctl.flush_req ? ctl.flush_stage : '0;
        pend_f    = flush_pending_reg ? pend_stage_reg : '0;
        eff_f     = (req_f > pend_f) ? req_f : pend_f;
        flush_any = ctl.flush_req || flush_pending_reg;
        // A flush can only go ahead if it bubbles every stage the stall holds.
        apply     = flush_any && ctl.rdy && (!stall_any || (stall_lvl <= eff_f));
    end

    pipeline_ctrl_thermo_mask #(.N(NUM_STAGES), .IW(SW)) u_stall_mask (
        .idx   (stall_lvl),
        .valid (stall_any),
        .mask  (stall_mask)
    );

    pipeline_ctrl_thermo_mask #(.N(NUM_STAGES), .IW(SW)) u_flush_mask (
        .idx   (eff_f),
        .valid (flush_any),
        .mask  (flush_mask)
    );

    always_comb begin
        stall_o = '0;
        if (rst == RST_ENABLE)  stall_o = '0;
        else if (!ctl.rdy)      stall_o = {NUM_STAGES{STOP}};
        else if (apply)         stall_o = '0;
        else                    stall_o = stall_mask;
    end

    assign ctl.stall         = stall_o;
    assign ctl.flush         = ((rst != RST_ENABLE) && apply) ? flush_mask : '0;
    assign ctl.flush_pending = flush_pending_reg;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            flush_pending_reg <= 1'b0;
            pend_stage_reg    <= '0;
        end else if (apply) begin
            flush_pending_reg <= 1'b0;
            pend_stage_reg    <= '0;
        end else if (flush_any) begin
            flush_pending_reg <= 1'b1;
            pend_stage_reg    <= eff_f;
        end
    end

    if (TIMEOUT > 0) begin : g_wd
        localparam int            CW     = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

        logic [CW-1:0] wd_cnt_reg;
        logic [CW-1:0] wd_cnt_next;
        logic          timeout_reg;

        // Frozen (rdy=0) cycles leave the count untouched.
        always_comb begin
            wd_cnt_next = wd_cnt_reg;
            if (ctl.rdy) begin
                if (stall_o != '0) begin
                    if (wd_cnt_reg != WD_MAX) wd_cnt_next = wd_cnt_reg + CW'(1);
                end else begin
                    wd_cnt_next = '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst == RST_ENABLE) begin
                wd_cnt_reg  <= '0;
                timeout_reg <= 1'b0;
            end else begin
                wd_cnt_reg <= wd_cnt_next;
                if (wd_cnt_next == WD_MAX) timeout_reg <= 1'b1;
            end
        end

        assign ctl.stall_timeout = timeout_reg;
    end else begin : g_no_wd
        assign ctl.stall_timeout = 1'b0;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (stall_o != '0) perf_stall_reg <= perf_stall_reg + 32'd1;
            if (apply)         perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign ctl.perf_stall_cycles = perf_stall_reg;
    assign ctl.perf_flush_count  = perf_flush_reg;
`else
    assign ctl.perf_stall_cycles = 32'd0;
    assign ctl.perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed test of pipeline_ctrl (6 stages, 3 requesters, TIMEOUT=8).
// Inputs change 1 ns after a rising edge; outputs are sampled before the next.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.NUM_STAGES(6), .NUM_REQ(3)) bus ();

    pipeline_ctrl #(
        .NUM_STAGES (6),
        .NUM_REQ    (3),
        .REQ_STAGE  (9'b011_011_010),
        .TIMEOUT    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [2:0] sr, input logic fr, input logic [2:0] fs);
        bus.rdy         = r;
        bus.stall_req   = sr;
        bus.flush_req   = fr;
        bus.flush_stage = fs;
        #1;
    endtask

    initial begin
        // Reset with every request asserted
        rst = 1'b1;
        drive(1'b1, 3'b111, 1'b1, 3'd2);
        check_eq("rst_stall", 32'(bus.stall), 32'h00);
        check_eq("rst_flush", 32'(bus.flush), 32'h00);
        tick();
        tick();
        check_eq("rst_pending", 32'(bus.flush_pending), 32'd0);
        check_eq("rst_timeout", 32'(bus.stall_timeout), 32'd0);
        rst = 1'b0;
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        tick();

        // Stall level merge
        drive(1'b1, 3'b011, 1'b0, 3'd0);
        check_eq("merge_011", 32'(bus.stall), 32'b001111);
        check_eq("merge_011_flush", 32'(bus.flush), 32'h00);
        tick();
        drive(1'b1, 3'b001, 1'b0, 3'd0);
        check_eq("merge_001", 32'(bus.stall), 32'b000111);
        tick();
        drive(1'b1, 3'b101, 1'b0, 3'd0);
        check_eq("merge_deepest_101", 32'(bus.stall), 32'b001111);
        tick();
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        check_eq("merge_000", 32'(bus.stall), 32'b000000);
        tick();
        drive(1'b0, 3'b000, 1'b0, 3'd0);
        check_eq("rdy0_freeze", 32'(bus.stall), 32'b111111);
        tick();

        // Flush blocked by rdy=0, applied when rdy returns
        drive(1'b0, 3'b000, 1'b1, 3'd2);
        check_eq("blk_rdy_flush", 32'(bus.flush), 32'h00);
        check_eq("blk_rdy_stall", 32'(bus.stall), 32'b111111);
        tick();
        drive(1'b0, 3'b000, 1'b0, 3'd0);
        check_eq("blk_rdy_pend1", 32'(bus.flush_pending), 32'd1);
        tick();
        check_eq("blk_rdy_pend2", 32'(bus.flush_pending), 32'd1);
        tick();
        check_eq("blk_rdy_pend3", 32'(bus.flush_pending), 32'd1);
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        check_eq("blk_rdy_apply", 32'(bus.flush), 32'b000111);
        check_eq("blk_rdy_apply_stall", 32'(bus.stall), 32'h00);
        tick();
        check_eq("blk_rdy_pend_clr", 32'(bus.flush_pending), 32'd0);
        check_eq("blk_rdy_once", 32'(bus.flush), 32'h00);

        // Flush shallower than stall: deferred, merged, then applied once
        drive(1'b1, 3'b010, 1'b1, 3'd1);
        check_eq("deep_blocked", 32'(bus.flush), 32'h00);
        check_eq("deep_stall", 32'(bus.stall), 32'b001111);
        tick();
        check_eq("deep_pend", 32'(bus.flush_pending), 32'd1);
        drive(1'b1, 3'b010, 1'b1, 3'd2);
        check_eq("deep_blocked2", 32'(bus.flush), 32'h00);
        tick();
        check_eq("deep_pend2", 32'(bus.flush_pending), 32'd1);
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        check_eq("merge_apply", 32'(bus.flush), 32'b000111);
        check_eq("merge_apply_stall", 32'(bus.stall), 32'h00);
        tick();
        check_eq("merge_pend_clr", 32'(bus.flush_pending), 32'd0);
        check_eq("merge_once", 32'(bus.flush), 32'h00);

        // Flush at the same or deeper level than the stall wins
        drive(1'b1, 3'b001, 1'b1, 3'd3);
        check_eq("same_lvl_flush", 32'(bus.flush), 32'b001111);
        check_eq("same_lvl_stall", 32'(bus.stall), 32'h00);
        tick();
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        check_eq("same_lvl_pend", 32'(bus.flush_pending), 32'd0);

        // Pending flush plus new request in the applying cycle
        drive(1'b0, 3'b000, 1'b1, 3'd4);
        tick();
        drive(1'b1, 3'b000, 1'b1, 3'd1);
        check_eq("merged_pend_req", 32'(bus.flush), 32'b011111);
        tick();
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        check_eq("no_second_flush", 32'(bus.flush), 32'h00);
        check_eq("no_second_pend", 32'(bus.flush_pending), 32'd0);

`ifdef PIPE_CTRL_PERF_EN
        check_eq("perf_flush_count", bus.perf_flush_count, 32'd4);
`else
        check_eq("perf_flush_off", bus.perf_flush_count, 32'd0);
        check_eq("perf_stall_off", bus.perf_stall_cycles, 32'd0);
`endif

        // Watchdog: 7 stalled cycles then a free one never trips
        drive(1'b1, 3'b001, 1'b0, 3'd0);
        repeat (7) tick();
        check_eq("wd_7", 32'(bus.stall_timeout), 32'd0);
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        tick();
        check_eq("wd_free", 32'(bus.stall_timeout), 32'd0);

        // Watchdog with frozen cycles interleaved: 4 + (3 frozen) + 3 + 1
        drive(1'b1, 3'b001, 1'b0, 3'd0);
        repeat (4) tick();
        drive(1'b0, 3'b001, 1'b0, 3'd0);
        repeat (3) tick();
        drive(1'b1, 3'b001, 1'b0, 3'd0);
        repeat (3) tick();
        check_eq("wd_gap_7", 32'(bus.stall_timeout), 32'd0);
        tick();
        check_eq("wd_gap_8", 32'(bus.stall_timeout), 32'd1);
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        tick();
        check_eq("wd_sticky", 32'(bus.stall_timeout), 32'd1);

        // Reset mid-operation drops a pending flush and clears the watchdog
        drive(1'b0, 3'b000, 1'b1, 3'd2);
        tick();
        check_eq("rst_mid_pend_set", 32'(bus.flush_pending), 32'd1);
        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 3'd0);
        tick();
        check_eq("rst_drop_pend", 32'(bus.flush_pending), 32'd0);
        check_eq("rst_clr_timeout", 32'(bus.stall_timeout), 32'd0);
        rst = 1'b0;
        drive(1'b1, 3'b000, 1'b0, 3'd0);
        check_eq("rst_no_flush", 32'(bus.flush), 32'h00);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised pipeline hazard controller. It generates per-stage stall and flush vectors for the in-order RISC-V pipeline (stage 0 = PC/IF ... stage NUM_STAGES-1 = WB).
- It merges NUM_REQ stall requesters, each bound at elaboration to a stall depth.
- It honours a global memory-ready input and latches branch/exception flush requests that cannot be applied yet.
- It runs a stall watchdog. Sits beside the stage registers; all stage modules consume stall/flush.

Parameters:
- NUM_STAGES, 6, number of pipeline stages (stall/flush vector width), 2..16.
- NUM_REQ, 3, number of stall request inputs, 1..8.
- SW, $clog2(NUM_STAGES), stage index width (derived; not overridden).
- REQ_STAGE, {3'd3,3'd3,3'd2}, packed NUM_REQ*SW: deepest stage frozen by request i (req0=ID→2, req1=MEM→3, req2=RAM→3).
- TIMEOUT, 1024, consecutive stalled cycles before stall_timeout sets; 0 disables the watchdog.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- rdy, input, 1, global ready; 0 freezes the whole pipeline.
- stall_req, input, NUM_REQ, bit i=1 requests a stall up to REQ_STAGE[i].
- flush_req, input, 1, flush/redirect request.
- flush_stage, input, SW, deepest stage to flush (inclusive).
- stall, output, NUM_STAGES, bit k=1 freezes stage k register.
- flush, output, NUM_STAGES, bit k=1 loads a bubble into stage k.
- flush_pending, output, 1, registered; a flush is latched but not yet applied.
- stall_timeout, output, 1, sticky watchdog flag.
- perf_stall_cycles, output, 32, stalled-cycle counter (see Optional Feature).
- perf_flush_count, output, 32, applied-flush counter (see Optional Feature).

Behaviour:
- Clock and reset: single clock domain, clk; rst is synchronous, active-high.
- Reset values: flush_pending=0, pending stage=0, watchdog count=0, stall_timeout=0, perf counters=0. stall and flush read all zero during any cycle with rst=1.
- Stall level L: max REQ_STAGE[i] over asserted stall_req[i]; "none" if no request.
- stall is combinational, 0-cycle latency, a thermometer: stall[k]=1 for k≤L.
- Priority fix vs. legacy controller: multiple requests resolve to the deepest level, not to the first listed.
- rdy=0: stall = all ones, flush = 0, regardless of requests.
- Effective flush: F = max(flush_stage if flush_req, pending stage if flush_pending).
- Flush applies this cycle iff (flush_req or flush_pending) and rdy=1 and (L is none or L≤F).
- On apply:
  - flush[k]=1 for k≤F, 0 above.
  - stall[k] forced 0 for k≤F, so stall = 0 whole-vector.
  - flush_pending clears next cycle.
  - perf_flush_count += 1.
- Flush blocked (rdy=0 or L>F): flush=0. Next cycle flush_pending=1 and pending stage=F; requests merge by max.
- flush_req during an applying cycle with a pending flush: single apply at merged F; no second flush.
- Watchdog:
  - Counts consecutive cycles with rdy=1 and stall≠0; resets to 0 on any cycle with stall=0; saturates at TIMEOUT.
  - Rdy=0 cycles neither count nor reset the watchdog.
  - When count reaches TIMEOUT, stall_timeout=1 on the following edge; cleared only by rst.
- Reset mid-operation (stall or pending flush active): all state cleared on that edge; the pending flush is dropped.

Optional Feature:
- PIPE_CTRL_PERF_EN defined: perf_stall_cycles increments on every cycle with rst=0 and stall≠0 (rdy=0 cycles included). perf_flush_count increments on every applied flush. Both wrap at 2^32.
- Not defined: both ports tied to 32'd0, no counter registers synthesised.

Decomposition:
- Shared package/header: stage index constants (STG_PC..STG_WB), STOP/RstEnable-style defines, SW width, default REQ_STAGE value.
- One natural sub-module: thermo_mask (index + valid → NUM_STAGES-bit thermometer), used for both stall and flush.

Test Plan:
- Reset: rst=1 for 2 cycles with stall_req=3'b111, flush_req=1 → stall=0, flush=0, flush_pending=0, stall_timeout=0.
- Priority merge: stall_req=3'b011 → stall=6'b001111; stall_req=3'b001 → 6'b000111; 3'b000 → 6'b000000.
- Flush blocked by rdy: rdy=0, flush_req=1, flush_stage=2 for 1 cycle; 3 cycles later rdy=1 → flush_pending=1 meanwhile; flush=6'b000111 on first rdy=1 cycle; flush_pending=0 after.
- Flush vs. deeper stall, then merge:
  - flush_stage=1 with stall_req=3'b010 (L=3) → flush held pending.
  - Second flush_req at flush_stage=2 → merged F=2.
  - Stall drops → one flush=6'b000111.
- Flush wins same level: stall_req=3'b001 (L=2), flush_req, flush_stage=3 → flush=6'b001111, stall=0.
- Watchdog: TIMEOUT=8, stall_req=3'b001 held 8 cycles → stall_timeout=1 after 8th; with 7 cycles then a free cycle → stays 0.
- Watchdog with rdy=0 cycles interleaved → count neither advances nor clears.
